// File: rtl/frequency_meter.sv
// Gated frequency counter: counts rising edges of sig_in over GATE_CYCLES clk cycles.
// Define FREQMETER_SYNC_EN to pass sig_in through a 2-flop synchronizer before edge detection.
module frequency_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  // state | meaning
  // IDLE  | not measuring; gate and edge counters held at 0
  // GATE  | gate window running; gate_cnt walks 0..GATE_CYCLES-1
  typedef enum logic {IDLE = 1'b0, GATE = 1'b1} state_t;

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    LAST    = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;
  logic             samp;
  logic             prev;
  logic             rise;
  logic             at_max;
  logic [CNT_W-1:0] edge_next;
  logic             sat_next;

`ifdef FREQMETER_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      samp <= 1'b0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], sig_in};
      samp <= sync[1];
      prev <= samp;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      samp <= 1'b0;
      prev <= 1'b0;
    end else begin
      samp <= sig_in;
      prev <= samp;
    end
  end
`endif

  assign rise      = samp & ~prev;
  assign at_max    = (edge_cnt == CNT_MAX);
  assign edge_next = (rise && !at_max) ? edge_cnt + 1'b1 : edge_cnt;
  assign sat_next  = sat | (rise & at_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq_count <= '0;
      valid      <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          if (en) begin
            state <= GATE;
            busy  <= 1'b1;
          end
        end
        GATE: begin
          if (gate_cnt == LAST) begin
            // a window that reaches its last cycle always reports, even if en just fell
            freq_count <= edge_next;
            ovf        <= sat_next;
            valid      <= 1'b1;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            if (!en) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (!en) begin
            state    <= IDLE;
            busy     <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_next;
            sat      <= sat_next;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frequency_meter.sv
// Directed bench for frequency_meter: an 8-bit and a 3-bit instance, 100-cycle gate windows.
module tb_frequency_meter;

  logic       clk;
  logic       rst;
  logic       en_a;
  logic       en_b;
  logic       sig_in;
  logic       man_sig;
  logic       gen_sig;
  int         gen_period;
  int         gen_ph;
  logic [7:0] freq_a;
  logic       valid_a, ovf_a, busy_a;
  logic [2:0] freq_b;
  logic       valid_b, ovf_b, busy_b;
  int         tests;
  int         failures;

  assign sig_in = (gen_period != 0) ? gen_sig : man_sig;

  frequency_meter #(.GATE_CYCLES(100), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .sig_in(sig_in),
    .freq_count(freq_a), .valid(valid_a), .ovf(ovf_a), .busy(busy_a)
  );

  frequency_meter #(.GATE_CYCLES(100), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .sig_in(sig_in),
    .freq_count(freq_b), .valid(valid_b), .ovf(ovf_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // periodic source changes on negedge so posedge sampling never races it
  initial begin
    gen_ph  = 0;
    gen_sig = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_period != 0) begin
        gen_ph  = (gen_ph + 1) % gen_period;
        gen_sig = (gen_ph < gen_period / 2);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input bit sel, input int max, input string tag, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!(sel ? valid_b : valid_a) && n < max);
    tests++;
    assert ((sel ? valid_b : valid_a) === 1'b1) else begin
      failures++;
      $error("FAIL %s: observed valid=0 after %0d cycles expected valid=1", tag, n);
    end
  endtask

  initial begin
    int n;
    int seen;
    tests      = 0;
    failures   = 0;
    gen_period = 0;
    man_sig    = 1'b0;
    rst        = 1'b1;
    en_a       = 1'b0;
    en_b       = 1'b0;

    // reset state
    tick(3);
    check("rst_freq", 32'(freq_a), 0);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_ovf", 32'(ovf_a), 0);
    check("rst_busy", 32'(busy_a), 0);

    // release with en=1: GATE on the next cycle; period-10 source gives 10 per window
    rst        = 1'b0;
    en_a       = 1'b1;
    gen_period = 10;
    tick(1);
    check("busy_after_rst_release", 32'(busy_a), 1);
    wait_valid(1'b0, 250, "p10_first", n);
    wait_valid(1'b0, 250, "p10_second", n);
    check("p10_gap", 32'(n), 100);
    check("p10_freq", 32'(freq_a), 10);
    check("p10_ovf", 32'(ovf_a), 0);
    tick(1);
    check("valid_one_cycle", 32'(valid_a), 0);

    // constant high, then constant low: zero edges but windows still report
    gen_period = 0;
    man_sig    = 1'b1;
    wait_valid(1'b0, 250, "const1_first", n);
    wait_valid(1'b0, 250, "const1_second", n);
    check("const1_gap", 32'(n), 100);
    check("const1_freq", 32'(freq_a), 0);
    man_sig = 1'b0;
    wait_valid(1'b0, 250, "const0", n);
    check("const0_gap", 32'(n), 100);
    check("const0_freq", 32'(freq_a), 0);

    // en dropped at gate cycle 50: partial window discarded
    gen_period = 10;
    wait_valid(1'b0, 250, "abort_pre1", n);
    wait_valid(1'b0, 250, "abort_pre2", n);
    check("abort_pre_freq", 32'(freq_a), 10);
    tick(50);
    en_a = 1'b0;
    tick(1);
    check("abort_busy", 32'(busy_a), 0);
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      if (valid_a) seen++;
      tick(1);
    end
    check("abort_no_valid", 32'(seen), 0);
    check("abort_freq_hold", 32'(freq_a), 10);
    en_a = 1'b1;
    wait_valid(1'b0, 250, "abort_restart", n);
    check("abort_restart_latency", 32'(n), 101);
    check("abort_restart_freq", 32'(freq_a), 10);

    // reset mid-window, released while the source is low
    tick(30);
    rst = 1'b1;
    tick(1);
    check("midrst_freq", 32'(freq_a), 0);
    check("midrst_valid", 32'(valid_a), 0);
    check("midrst_busy", 32'(busy_a), 0);
    check("midrst_ovf", 32'(ovf_a), 0);
    n = 0;
    while (gen_ph != 5 && n < 20) begin
      tick(1);
      n++;
    end
    check("midrst_phase_found", 32'(gen_ph), 5);
    rst = 1'b0;
    wait_valid(1'b0, 250, "midrst_window", n);
    check("midrst_latency", 32'(n), 101);
    check("midrst_count", 32'(freq_a), 10);

    // single pulse placed so its detection latency decides which window it lands in
    gen_period = 0;
    man_sig    = 1'b0;
    wait_valid(1'b0, 250, "pulse_align", n);
    tick(98);
    man_sig = 1'b1;
    tick(1);
    man_sig = 1'b0;
    wait_valid(1'b0, 5, "pulse_win1", n);
    check("pulse_win1_latency", 32'(n), 1);
`ifdef FREQMETER_SYNC_EN
    check("pulse_win1_freq", 32'(freq_a), 0);
`else
    check("pulse_win1_freq", 32'(freq_a), 1);
`endif
    wait_valid(1'b0, 250, "pulse_win2", n);
    check("pulse_win2_gap", 32'(n), 100);
`ifdef FREQMETER_SYNC_EN
    check("pulse_win2_freq", 32'(freq_a), 1);
`else
    check("pulse_win2_freq", 32'(freq_a), 0);
`endif

    // 3-bit counter: period 4 saturates at 7, period 20 gives 5 with ovf cleared
    check("b_idle_busy", 32'(busy_b), 0);
    check("b_idle_valid", 32'(valid_b), 0);
    en_b       = 1'b1;
    gen_period = 4;
    wait_valid(1'b1, 250, "sat_first", n);
    wait_valid(1'b1, 250, "sat_second", n);
    check("sat_gap", 32'(n), 100);
    check("sat_freq", 32'(freq_b), 7);
    check("sat_ovf", 32'(ovf_b), 1);
    gen_period = 20;
    wait_valid(1'b1, 250, "p20_first", n);
    wait_valid(1'b1, 250, "p20_second", n);
    check("p20_freq", 32'(freq_b), 5);
    check("p20_ovf", 32'(ovf_b), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
